// File: rtl/dp_operand_stage.sv
// dp_operand_stage: decodes an ARM data-processing instruction into registered ALU operands
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             drop held or in-progress instruction, highest priority
//   in_valid/in_ready upstream handshake; in_ready is combinational
//   in_instr          instruction word; in_rn/rm/rs_data register-file read data
//   in_carry          CPSR C flag, sampled at accept
//   out_valid/out_ready downstream handshake
//   out_opcode, out_operand1, out_operand2, out_shifter_carry, out_set_flags, out_rd
module dp_operand_stage #(
    parameter int REG_SHIFT_EXTRA_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_rn_data,
    input  logic [31:0] in_rm_data,
    input  logic [31:0] in_rs_data,
    input  logic        in_carry,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic [31:0] out_operand1,
    output logic [31:0] out_operand2,
    output logic        out_shifter_carry,
    output logic        out_set_flags,
    output logic [3:0]  out_rd
);
    typedef enum logic [1:0] {EMPTY, REGSHIFT, FULL} state_t;
    state_t state;
    logic [31:0] cap_instr, cap_rn, cap_rm, cap_rs;
    logic        cap_carry;
    logic [31:0] ins, rn, rm, rs;
    logic        c, accept, two_cycle, load, busy;
    logic [32:0] sh;

    function automatic logic [31:0] ror32(input logic [31:0] x, input logic [4:0] n);
        logic [63:0] t;
        t = {x, x} >> n;
        return t[31:0];
    endfunction

    // Returns {carry, operand2}. The 33-bit shifts put the carry bit next to
    // the result so that amounts of 32 and above fall out of the shift itself.
    function automatic logic [32:0] shifter(input logic [31:0] i, input logic [31:0] m,
                                            input logic [31:0] s, input logic ci);
        logic [31:0] imm, o;
        logic [7:0]  amt, eff;
        logic [32:0] l, r, a;
        logic        zero;
        imm  = ror32({24'd0, i[7:0]}, {i[11:8], 1'b0});
        amt  = i[4] ? s[7:0] : {3'd0, i[11:7]};
        zero = amt == 8'd0;
        // immediate LSR/ASR #0 encode a shift by 32
        eff  = (zero && !i[4]) ? 8'd32 : amt;
        l    = {1'b0, m} << amt;
        r    = {m, 1'b0} >> eff;
        a    = $signed({m, 1'b0}) >>> eff;
        o    = ror32(m, amt[4:0]);
        return i[25] ? {(i[11:8] == 4'd0) ? ci : imm[31], imm} :
               (zero && (i[4] || i[6:5] == 2'b00)) ? {ci, m} :
               (zero && i[6:5] == 2'b11) ? {m[0], ci, m[31:1]} :
               (i[6:5] == 2'b00) ? l :
               (i[6:5] == 2'b01) ? {r[0], r[32:1]} :
               (i[6:5] == 2'b10) ? {a[0], a[32:1]} : {o[31], o};
    endfunction

    assign busy      = state == REGSHIFT;
    assign in_ready  = !flush && (state == EMPTY || (state == FULL && out_ready));
    assign accept    = in_valid && in_ready;
    assign two_cycle = REG_SHIFT_EXTRA_CYCLE != 0 && !in_instr[25] && in_instr[4];
    assign load      = !flush && (busy || (accept && !two_cycle));
    assign out_valid = state == FULL;
    assign ins       = busy ? cap_instr : in_instr;
    assign rn        = busy ? cap_rn : in_rn_data;
    assign rm        = busy ? cap_rm : in_rm_data;
    assign rs        = busy ? cap_rs : in_rs_data;
    assign c         = busy ? cap_carry : in_carry;
    assign sh        = shifter(ins, rm, rs, c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= EMPTY;
            cap_instr         <= '0;
            cap_rn            <= '0;
            cap_rm            <= '0;
            cap_rs            <= '0;
            cap_carry         <= 1'b0;
            out_opcode        <= '0;
            out_operand1      <= '0;
            out_operand2      <= '0;
            out_shifter_carry <= 1'b0;
            out_set_flags     <= 1'b0;
            out_rd            <= '0;
        end else begin
            if (accept) begin
                cap_instr <= in_instr;
                cap_rn    <= in_rn_data;
                cap_rm    <= in_rm_data;
                cap_rs    <= in_rs_data;
                cap_carry <= in_carry;
            end
            if (load) begin
                out_opcode        <= ins[24:21];
                out_operand1      <= rn;
                out_operand2      <= sh[31:0];
                out_shifter_carry <= sh[32];
                out_set_flags     <= ins[20];
                out_rd            <= ins[15:12];
            end
            state <= flush ? EMPTY :
                     busy ? FULL :
                     accept ? (two_cycle ? REGSHIFT : FULL) :
                     (state == FULL && out_ready) ? EMPTY : state;
        end
    end
endmodule

// File: tb/tb_dp_operand_stage.sv
// tb_dp_operand_stage: vector table, corner sequences and random traffic against a transaction model
module tb_dp_operand_stage;
    logic        clk, rst_n, flush, in_valid, in_ready, in_carry;
    logic [31:0] in_instr, in_rn_data, in_rm_data, in_rs_data;
    logic        out_valid, out_ready, out_shifter_carry, out_set_flags;
    logic [3:0]  out_opcode, out_rd;
    logic [31:0] out_operand1, out_operand2;
    logic [74:0] dut_b;
    int          vectors = 0;
    int          miscompares = 0;

    dp_operand_stage #(.REG_SHIFT_EXTRA_CYCLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_rn_data(in_rn_data), .in_rm_data(in_rm_data), .in_rs_data(in_rs_data),
        .in_carry(in_carry), .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_operand1(out_operand1), .out_operand2(out_operand2),
        .out_shifter_carry(out_shifter_carry), .out_set_flags(out_set_flags), .out_rd(out_rd)
    );

    assign dut_b = {out_valid, out_opcode, out_operand1, out_operand2,
                    out_shifter_carry, out_set_flags, out_rd};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins, rn, rm, rs;
        logic        c;
        logic [31:0] op2;
        logic        cy;
    } vec_t;

    // Reference shifter written straight from the ARM operand2 rules
    function automatic logic [32:0] model_shift(input logic [31:0] i, input logic [31:0] m,
                                                input logic [31:0] s, input logic ci);
        int          n;
        logic [31:0] v;
        if (i[25]) begin
            v = {24'd0, i[7:0]};
            for (int k = 0; k < 2 * i[11:8]; k++) v = {v[0], v[31:1]};
            return {(i[11:8] == 0) ? ci : v[31], v};
        end
        if (!i[4]) begin
            n = i[11:7];
            case (i[6:5])
                2'b00:   return (n == 0) ? {ci, m} : {m[32-n], m << n};
                2'b01:   return (n == 0) ? {m[31], 32'd0} : {m[n-1], m >> n};
                2'b10:   return (n == 0) ? {m[31], {32{m[31]}}} : {m[n-1], 32'($signed(m) >>> n)};
                default: return (n == 0) ? {m[0], ci, m[31:1]} : {m[n-1], (m >> n) | (m << (32 - n))};
            endcase
        end
        n = s[7:0];
        if (n == 0) return {ci, m};
        case (i[6:5])
            2'b00:   return (n < 32) ? {m[32-n], m << n} : (n == 32) ? {m[0], 32'd0} : 33'd0;
            2'b01:   return (n < 32) ? {m[n-1], m >> n} : (n == 32) ? {m[31], 32'd0} : 33'd0;
            2'b10:   return (n < 32) ? {m[n-1], 32'($signed(m) >>> n)} : {m[31], {32{m[31]}}};
            default: begin
                n = n % 32;
                return (n == 0) ? {m[31], m} : {m[n-1], (m >> n) | (m << (32 - n))};
            end
        endcase
    endfunction

    function automatic logic [73:0] payload(input logic [31:0] i, input logic [31:0] rn,
                                            input logic [32:0] sh);
        return {i[24:21], rn, sh[31:0], sh[32], i[20], i[15:12]};
    endfunction

    function automatic logic [73:0] expect_of(input logic [31:0] i, input logic [31:0] rn,
                                              input logic [31:0] rm, input logic [31:0] rs,
                                              input logic c);
        return payload(i, rn, model_shift(i, rm, rs, c));
    endfunction

    task automatic chk(input string nm, input logic [74:0] act, input logic [74:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [31:0] rs, input logic c);
        in_instr = i; in_rn_data = rn; in_rm_data = rm; in_rs_data = rs; in_carry = c;
    endtask

    // One-shot accept from EMPTY; returns once the result is visible
    task automatic issue(input logic [31:0] i, input logic [31:0] rn, input logic [31:0] rm,
                         input logic [31:0] rs, input logic c);
        drive(i, rn, rm, rs, c);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        drive($urandom, $urandom, $urandom, $urandom, 1'b0);
        if (!i[25] && i[4]) begin
            chk("mid_ready", {74'd0, in_ready}, 75'd0);
            chk("mid_valid", {74'd0, out_valid}, 75'd0);
            step();
        end
    endtask

    vec_t        tbl[14];
    logic [31:0] bp[3];
    logic [73:0] e, mexp;
    logic        have, acc, exp_ready;
    int          wt;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        drive(0, 0, 0, 0, 0);
        tbl[0]  = '{32'hE29010FF, 32'd5, 32'd0, 32'd0, 1'b1, 32'h000000FF, 1'b1};
        tbl[1]  = '{32'hE29014FF, 32'd5, 32'd0, 32'd0, 1'b1, 32'hFF000000, 1'b1};
        tbl[2]  = '{32'hE29010FF, 32'd7, 32'd0, 32'd0, 1'b0, 32'h000000FF, 1'b0};
        tbl[3]  = '{32'hE1B02021, 32'd0, 32'h80000001, 32'd0, 1'b0, 32'h00000000, 1'b1};
        tbl[4]  = '{32'hE1B02041, 32'd0, 32'h80000001, 32'd0, 1'b0, 32'hFFFFFFFF, 1'b1};
        tbl[5]  = '{32'hE1B02061, 32'd0, 32'h80000001, 32'd0, 1'b0, 32'h40000000, 1'b1};
        tbl[6]  = '{32'hE1B02081, 32'd0, 32'h80000001, 32'd0, 1'b0, 32'h00000002, 1'b1};
        tbl[7]  = '{32'hE1B02311, 32'd0, 32'h80000001, 32'd0, 1'b1, 32'h80000001, 1'b1};
        tbl[8]  = '{32'hE1B02311, 32'd0, 32'h80000001, 32'd0, 1'b0, 32'h80000001, 1'b0};
        tbl[9]  = '{32'hE1B02311, 32'd0, 32'h80000001, 32'd32, 1'b0, 32'h00000000, 1'b1};
        tbl[10] = '{32'hE1B02311, 32'd0, 32'h80000001, 32'd33, 1'b1, 32'h00000000, 1'b0};
        tbl[11] = '{32'hE1B02371, 32'd0, 32'h80000001, 32'd32, 1'b0, 32'h80000001, 1'b1};
        tbl[12] = '{32'hE1B02351, 32'd0, 32'h80000001, 32'd40, 1'b0, 32'hFFFFFFFF, 1'b1};
        tbl[13] = '{32'hE1B02331, 32'd0, 32'h80000001, 32'd32, 1'b0, 32'h00000000, 1'b1};
        #1;
        chk("reset_outputs", dut_b, 75'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("reset_ready", {74'd0, in_ready}, 75'd1);

        foreach (tbl[k]) begin
            chk($sformatf("tbl%0d_ready", k), {74'd0, in_ready}, 75'd1);
            issue(tbl[k].ins, tbl[k].rn, tbl[k].rm, tbl[k].rs, tbl[k].c);
            chk($sformatf("tbl%0d", k), dut_b,
                {1'b1, payload(tbl[k].ins, tbl[k].rn, {tbl[k].cy, tbl[k].op2})});
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            chk($sformatf("tbl%0d_drain", k), {74'd0, out_valid}, 75'd0);
        end

        // Backpressure with three queued instructions
        bp[0] = 32'hE0812003; bp[1] = 32'hE04540A3; bp[2] = 32'hE1B06C47;
        drive(bp[0], 32'd11, 32'h1234, 32'd0, 1'b1);
        in_valid = 1'b1;
        step();
        e = expect_of(bp[0], 32'd11, 32'h1234, 32'd0, 1'b1);
        drive(bp[1], 32'd22, 32'hF0000003, 32'd0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_ready_low", {74'd0, in_ready}, 75'd0);
            chk("bp_hold", dut_b, {1'b1, e});
            step();
        end
        out_ready = 1'b1;
        #1;
        chk("bp_ready_release", {74'd0, in_ready}, 75'd1);
        step();
        chk("bp_r1", dut_b, {1'b1, expect_of(bp[1], 32'd22, 32'hF0000003, 32'd0, 1'b0)});
        drive(bp[2], 32'd33, 32'h80000000, 32'd0, 1'b1);
        step();
        in_valid = 1'b0;
        chk("bp_r2", dut_b, {1'b1, expect_of(bp[2], 32'd33, 32'h80000000, 32'd0, 1'b1)});
        step();
        chk("bp_empty", {74'd0, out_valid}, 75'd0);
        out_ready = 1'b0;

        // Flush while FULL: no accept in the flush cycle, next accept normal
        issue(bp[0], 32'd1, 32'd2, 32'd0, 1'b0);
        flush = 1'b1;
        drive(bp[1], 32'd9, 32'h55, 32'd0, 1'b1);
        in_valid = 1'b1;
        #1;
        chk("flush_full_ready", {74'd0, in_ready}, 75'd0);
        step();
        flush = 1'b0;
        chk("flush_full_valid", {74'd0, out_valid}, 75'd0);
        step();
        in_valid = 1'b0;
        chk("flush_full_next", dut_b, {1'b1, expect_of(bp[1], 32'd9, 32'h55, 32'd0, 1'b1)});
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Flush while REGSHIFT
        drive(32'hE1B02311, 32'd0, 32'h80000001, 32'd4, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_rs_valid", {74'd0, out_valid}, 75'd0);
        step();
        chk("flush_rs_stays", {74'd0, out_valid}, 75'd0);
        issue(bp[2], 32'd3, 32'h7, 32'd0, 1'b0);
        chk("flush_rs_next", dut_b, {1'b1, expect_of(bp[2], 32'd3, 32'h7, 32'd0, 1'b0)});

        // Async reset mid-FULL, then mid-REGSHIFT
        rst_n = 1'b0;
        #1;
        chk("rst_full", dut_b, 75'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_full_ready", {74'd0, in_ready}, 75'd1);
        drive(32'hE1B02311, 32'd0, 32'h80000001, 32'd2, 1'b0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_rs", dut_b, 75'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_rs_discard", {74'd0, out_valid}, 75'd0);
        chk("rst_rs_ready", {74'd0, in_ready}, 75'd1);
        issue(tbl[0].ins, tbl[0].rn, tbl[0].rm, tbl[0].rs, tbl[0].c);
        chk("rst_first", dut_b, {1'b1, payload(tbl[0].ins, tbl[0].rn, {tbl[0].cy, tbl[0].op2})});
        out_ready = 1'b1;
        step();

        // Random traffic against a one-slot transaction model
        have = 1'b0; wt = 0; mexp = '0;
        for (int k = 0; k < 2000; k++) begin
            in_valid  = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            flush     = $urandom_range(0, 19) == 0;
            drive($urandom, $urandom, $urandom,
                  ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  1'($urandom_range(0, 1)));
            #1;
            exp_ready = !flush && (!have || (wt == 0 && out_ready));
            chk("rnd_ready", {74'd0, in_ready}, {74'd0, exp_ready});
            if (have && wt == 0) chk("rnd_out", dut_b, {1'b1, mexp});
            else chk("rnd_idle", {74'd0, out_valid}, 75'd0);
            acc = in_valid && exp_ready;
            @(posedge clk);
            if (flush) have = 1'b0;
            else begin
                if (have && wt > 0) wt = wt - 1;
                else if (have && out_ready) have = 1'b0;
                if (acc) begin
                    have = 1'b1;
                    mexp = expect_of(in_instr, in_rn_data, in_rm_data, in_rs_data, in_carry);
                    wt   = (!in_instr[25] && in_instr[4]) ? 1 : 0;
                end
            end
            #1;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
